// File: rtl/gray_step_monitor.sv
// gray_step_monitor: checks the Gray counter output stream sampled on En.
// Each sample is converted to binary and checked for a legal +0/+1 step.
// Overflow must rise exactly on the max->0 wrap and stay high afterwards.
// Legal wraps are counted, and the first fault is latched until Clear/Reset.
// Optional feature macro: GRAY_STEP_MONITOR_ERRCNT_EN adds ErrCount[7:0],
// a saturating count of every illegal sample, including those seen in FAULT.
module gray_step_monitor #(
  parameter int W      = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              En,
  input  logic [W-1:0]      Gray,
  input  logic              OverflowIn,
  output logic [W-1:0]      Bin,
  output logic              BinValid,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Error,
  output logic [1:0]        ErrCode,
  output logic [1:0]        State
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
  ,
  output logic [7:0]        ErrCount
`endif
);

  typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] MAXV = '1;

  state_t       state;
  logic [W-1:0] prev;
  logic         ovf_prev;
  logic [W-1:0] b_new;
  logic [W-1:0] step;
  logic         is_wrap;
  logic         bad;
  logic [1:0]   bad_code;

  assign State = state;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign b_new   = g2b(Gray);
  assign step    = b_new - prev;
  assign is_wrap = (step == ONE) && (prev == MAXV);

  // Classify the current sample against the previous one; illegal step wins.
  always_comb begin
    bad      = 1'b0;
    bad_code = 2'b00;
    if (step != '0 && step != ONE) begin
      bad      = 1'b1;
      bad_code = 2'b01;
    end else if (is_wrap && !OverflowIn) begin
      bad      = 1'b1;
      bad_code = 2'b10;
    end else if (!is_wrap && !ovf_prev && OverflowIn) begin
      bad      = 1'b1;
      bad_code = 2'b10;
    end else if (ovf_prev && !OverflowIn) begin
      bad      = 1'b1;
      bad_code = 2'b10;
    end
  end

  // Sample register, step checker FSM and wrap/fault bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Bin       <= '0;
      BinValid  <= 1'b0;
      WrapCount <= '0;
      Error     <= 1'b0;
      ErrCode   <= 2'b00;
      prev      <= '0;
      ovf_prev  <= 1'b0;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
      ErrCount  <= '0;
`endif
    end else if (Clear) begin
      // Bin and prev deliberately survive Clear; a simultaneous En is dropped.
      state     <= IDLE;
      BinValid  <= 1'b0;
      WrapCount <= '0;
      Error     <= 1'b0;
      ErrCode   <= 2'b00;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
      ErrCount  <= '0;
`endif
    end else if (En) begin
      Bin      <= b_new;
      BinValid <= 1'b1;
      prev     <= b_new;
      ovf_prev <= OverflowIn;
      case (state)
        IDLE:  state <= TRACK;
        TRACK: begin
          if (bad) begin
            state   <= FAULT;
            Error   <= 1'b1;
            ErrCode <= bad_code;
          end else if (is_wrap && WrapCount != '1) begin
            WrapCount <= WrapCount + WRAP_W'(1);
          end
        end
        FAULT: ;
        default: state <= IDLE;
      endcase
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
      // Keep counting illegal samples in FAULT; the first sample after IDLE is never checked.
      if (state != IDLE && bad && ErrCount != 8'hFF) ErrCount <= ErrCount + 8'd1;
`endif
    end else begin
      BinValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb_gray_step_monitor: directed vectors with hand-computed expectations.
// Expected sample responses are queued at issue time and checked by a
// monitor whenever BinValid is seen. A second instance with WRAP_W=2
// checks WrapCount saturation from the same stimulus.
module tb_gray_step_monitor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, Clear = 1'b0, En = 1'b0, OverflowIn = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic [2:0] Bin, Bin2;
  logic       BinValid, BinValid2, Error, Error2;
  logic [7:0] WrapCount;
  logic [1:0] WrapCount2;
  logic [1:0] ErrCode, ErrCode2, State, State2;
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
  logic [7:0] ErrCount, ErrCount2;
`endif

  gray_step_monitor #(.W(3), .WRAP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .Gray(Gray), .OverflowIn(OverflowIn),
    .Bin(Bin), .BinValid(BinValid), .WrapCount(WrapCount), .Error(Error),
    .ErrCode(ErrCode), .State(State)
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    , .ErrCount(ErrCount)
`endif
  );

  gray_step_monitor #(.W(3), .WRAP_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .Gray(Gray), .OverflowIn(OverflowIn),
    .Bin(Bin2), .BinValid(BinValid2), .WrapCount(WrapCount2), .Error(Error2),
    .ErrCode(ErrCode2), .State(State2)
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    , .ErrCount(ErrCount2)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] bin;
    logic [7:0] wc;
    logic       err;
    logic [1:0] code;
    logic [1:0] st;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int   nvec  = 0;
  int   nfail = 0;
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one En sample; the expected response is queued for the monitor.
  task automatic smp(input logic [2:0] g, input logic o, input logic [2:0] b, input logic [7:0] wc,
                     input logic e, input logic [1:0] c, input logic [1:0] s, input logic [7:0] ec);
    exp_t x;
    x.bin = b; x.wc = wc; x.err = e; x.code = c; x.st = s; x.ec = ec;
    Gray = g; OverflowIn = o; En = 1'b1;
    q.push_back(x);
    @(posedge Clk); #1;
    En = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] b);
    chk({tag, ".bin"}, 32'(Bin), 32'(b));
    chk({tag, ".vld"}, 32'(BinValid), 0);
    chk({tag, ".wc"}, 32'(WrapCount), 0);
    chk({tag, ".err"}, 32'(Error), 0);
    chk({tag, ".code"}, 32'(ErrCode), 0);
    chk({tag, ".st"}, 32'(State), 0);
    chk({tag, ".wc2"}, 32'(WrapCount2), 0);
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    chk({tag, ".ec"}, 32'(ErrCount), 0);
`endif
  endtask

  // Monitor: every BinValid pulse consumes one queued expectation.
  always @(negedge Clk) begin
    exp_t x;
    chk("vld2", 32'(BinValid2), 32'(BinValid));
    if (BinValid) begin
      if (q.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        x = q.pop_front();
        chk("bin", 32'(Bin), 32'(x.bin));
        chk("wc", 32'(WrapCount), 32'(x.wc));
        chk("err", 32'(Error), 32'(x.err));
        chk("code", 32'(ErrCode), 32'(x.code));
        chk("st", 32'(State), 32'(x.st));
        chk("wc2", 32'(WrapCount2), (x.wc > 8'd3) ? 32'd3 : 32'(x.wc));
        chk("bin2", 32'(Bin2), 32'(x.bin));
`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
        chk("ec", 32'(ErrCount), 32'(x.ec));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    chk_idle("reset", 3'd0);

    // Lap 1: legal steps, no overflow yet.
    for (int k = 0; k < 8; k++) smp(gtab[k], 1'b0, 3'(k), 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    // Wrap with overflow, then a second full lap with overflow held high.
    smp(3'b000, 1'b1, 3'd0, 8'd1, 1'b0, 2'b00, 2'b01, 8'd0);
    for (int k = 1; k < 8; k++) smp(gtab[k], 1'b1, 3'(k), 8'd1, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b000, 1'b1, 3'd0, 8'd2, 1'b0, 2'b00, 2'b01, 8'd0);

    // Illegal step 1 -> 3, then Bin keeps tracking while ErrCode stays frozen.
    smp(3'b001, 1'b1, 3'd1, 8'd2, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b010, 1'b1, 3'd3, 8'd2, 1'b1, 2'b01, 2'b10, 8'd1);
    smp(3'b110, 1'b1, 3'd4, 8'd2, 1'b1, 2'b01, 2'b10, 8'd1);
    smp(3'b000, 1'b0, 3'd0, 8'd2, 1'b1, 2'b01, 2'b10, 8'd2);

    // Clear together with En: sample discarded, Bin retained.
    Clear = 1'b1; En = 1'b1; Gray = 3'b110; OverflowIn = 1'b0;
    @(posedge Clk); #1;
    Clear = 1'b0; En = 1'b0;
    chk_idle("clear_en", 3'd0);

    // Wrap without overflow.
    for (int k = 0; k < 8; k++) smp(gtab[k], 1'b0, 3'(k), 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b000, 1'b0, 3'd0, 8'd0, 1'b1, 2'b10, 2'b10, 8'd1);

    // Overflow rising on a non-wrap sample.
    do_reset();
    chk_idle("reset2", 3'd0);
    smp(3'b000, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b001, 1'b0, 3'd1, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b011, 1'b1, 3'd2, 8'd0, 1'b1, 2'b10, 2'b10, 8'd1);

    // Sticky overflow falling 1 -> 0; first sample after Clear is unchecked.
    do_clear();
    chk_idle("clear", 3'd2);
    smp(3'b000, 1'b1, 3'd0, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b001, 1'b0, 3'd1, 8'd0, 1'b1, 2'b10, 2'b10, 8'd1);

    // Illegal step takes priority over an overflow violation.
    do_clear();
    smp(3'b001, 1'b0, 3'd1, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    smp(3'b100, 1'b1, 3'd7, 8'd0, 1'b1, 2'b01, 2'b10, 8'd1);

    // Four legal wraps: 8-bit counter reaches 4, 2-bit instance saturates at 3.
    do_reset();
    smp(3'b000, 1'b1, 3'd0, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);
    for (int lap = 1; lap <= 4; lap++) begin
      for (int k = 1; k < 8; k++) smp(gtab[k], 1'b1, 3'(k), 8'(lap - 1), 1'b0, 2'b00, 2'b01, 8'd0);
      smp(3'b000, 1'b1, 3'd0, 8'(lap), 1'b0, 2'b00, 2'b01, 8'd0);
    end
    // Three illegal samples in a row.
    smp(3'b010, 1'b1, 3'd3, 8'd4, 1'b1, 2'b01, 2'b10, 8'd1);
    smp(3'b000, 1'b1, 3'd0, 8'd4, 1'b1, 2'b01, 2'b10, 8'd2);
    smp(3'b110, 1'b1, 3'd4, 8'd4, 1'b1, 2'b01, 2'b10, 8'd3);

    // Reset wins over a simultaneous En.
    Reset = 1'b1; En = 1'b1; Gray = 3'b111; OverflowIn = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; En = 1'b0;
    chk_idle("reset_en", 3'd0);

    // After reset the next sample is treated as first.
    smp(3'b111, 1'b1, 3'd5, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0);

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
